player_control: RTL

PLAYER_CONTROL -- requirements
Module: player_control

---
 rtl/player_control.sv | 129 ++++++++++++
 1 files changed

// File: rtl/player_control.sv
// Player sprite movement controller: latches a key direction on move_tick,
// waits for game control to confirm the path is clear, then steps one pixel.
module player_control #(
  parameter int START_X  = 5,
  parameter int START_Y  = 5,
  parameter int WAIT_CYC = 2,
  parameter int MAX_X    = 155,
  parameter int MAX_Y    = 115
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_tick,
  input  logic [3:0] keys,
  input  logic       stop,
  input  logic       level_reset,
  output logic [3:0] direction,
  output logic [7:0] player_x,
  output logic [6:0] player_y
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CHECK,
    S_STEP
  } state_t;

  localparam logic [3:0] D_NONE  = 4'b0000;
  localparam logic [3:0] D_UP    = 4'b1000;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_LEFT  = 4'b0010;
  localparam logic [3:0] D_RIGHT = 4'b0001;

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);

  localparam logic [7:0] X_START = 8'(START_X);
  localparam logic [6:0] Y_START = 7'(START_Y);
  localparam logic [7:0] X_MAX   = 8'(MAX_X);
  localparam logic [6:0] Y_MAX   = 7'(MAX_Y);

  state_t        state;
  logic [3:0]    dir_q;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    key_pick;
  logic [7:0]    next_x;
  logic [6:0]    next_y;

  // Several keys may be held at once; UP wins, RIGHT loses.
  always_comb begin
    key_pick = D_NONE;
    priority case (1'b1)
      keys[3]: key_pick = D_UP;
      keys[2]: key_pick = D_DOWN;
      keys[1]: key_pick = D_LEFT;
      keys[0]: key_pick = D_RIGHT;
      default: key_pick = D_NONE;
    endcase
  end

  // Saturating one-pixel move along a single axis.
  always_comb begin
    next_x = player_x;
    next_y = player_y;
    case (dir_q)
      D_UP:    if (player_y != 7'd0)  next_y = player_y - 7'd1;
      D_DOWN:  if (player_y < Y_MAX)  next_y = player_y + 7'd1;
      D_LEFT:  if (player_x != 8'd0)  next_x = player_x - 8'd1;
      D_RIGHT: if (player_x < X_MAX)  next_x = player_x + 8'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      direction <= D_NONE;
      player_x  <= X_START;
      player_y  <= Y_START;
      dir_q     <= D_NONE;
      wait_cnt  <= '0;
    end else if (level_reset) begin
      state     <= S_IDLE;
      direction <= D_NONE;
      player_x  <= X_START;
      player_y  <= Y_START;
      dir_q     <= D_NONE;
      wait_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          direction <= D_NONE;
          if (move_tick && (keys != 4'b0000)) begin
            dir_q     <= key_pick;
            direction <= key_pick;
            wait_cnt  <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_CHECK: begin
          if (stop) begin
            state     <= S_IDLE;
            direction <= D_NONE;
          end else begin
            state <= S_STEP;
          end
        end
        S_STEP: begin
          player_x  <= next_x;
          player_y  <= next_y;
          direction <= D_NONE;
          state     <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          direction <= D_NONE;
        end
      endcase
    end
  end

endmodule
